// File: rtl/poly1305_msg_sched.sv
// poly1305_msg_sched: splits a Poly1305 message into padded 129-bit blocks for an external
// block processor, tracks the accumulator and forms the final tag.
module poly1305_msg_sched (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         key_valid,
    input  logic [255:0] key,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [4:0]   in_bytes,
    input  logic         in_last,
    output logic [127:0] pb_r,
    output logic [128:0] pb_m,
    output logic [129:0] pb_a,
    output logic         pb_start,
    input  logic         pb_done,
    input  logic [129:0] pb_a_out,
    output logic [127:0] tag,
    output logic         tag_valid,
    input  logic         tag_ready
);
    localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
    typedef enum logic [2:0] {IDLE, WAIT_MSG, PROC, FINAL, TAG_OUT} state_t;
    state_t       state;
    logic [129:0] acc;
    logic [127:0] s;
    logic         last;
    logic [4:0]   n;
    logic [7:0]   pad_pos;
    logic [127:0] data_mask;
    logic [128:0] m_blk;
    logic         accept;
    assign n         = in_bytes > 5'd16 ? 5'd16 : in_bytes;
    assign pad_pos   = {n, 3'b000};
    // a full chunk shifts the one out of range, so the mask wraps to all ones
    assign data_mask = (128'd1 << pad_pos) - 128'd1;
    assign m_blk     = {1'b0, in_data & data_mask} | (129'd1 << pad_pos);
    assign accept    = in_valid && in_ready;
    assign pb_a      = acc;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            pb_start  <= 1'b0;
            tag_valid <= 1'b0;
            pb_r      <= '0;
            pb_m      <= '0;
            acc       <= '0;
            s         <= '0;
            tag       <= '0;
            last      <= 1'b0;
        end else begin
            pb_start <= 1'b0;
            case (state)
                IDLE: if (key_valid) begin
                    pb_r     <= key[127:0] & CLAMP;
                    s        <= key[255:128];
                    acc      <= '0;
                    in_ready <= 1'b1;
                    state    <= WAIT_MSG;
                end
                WAIT_MSG: if (accept) begin
                    last <= in_last;
                    if (n != 5'd0) begin
                        pb_m     <= m_blk;
                        pb_start <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= PROC;
                    end else if (in_last) begin
                        in_ready <= 1'b0;
                        state    <= FINAL;
                    end
                end
                PROC: if (pb_done) begin
                    acc      <= pb_a_out;
                    in_ready <= !last;
                    state    <= last ? FINAL : WAIT_MSG;
                end
                FINAL: begin
                    tag       <= acc[127:0] + s;
                    tag_valid <= 1'b1;
                    state     <= TAG_OUT;
                end
                TAG_OUT: if (tag_ready) begin
                    tag_valid <= 1'b0;
                    pb_r      <= '0;
                    s         <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
